// File: rtl/mem_interface.sv
// Memory bus interface stage: latches address/write data from the datapath bus and
// sequences single-word SRAM read/write cycles with registered active-low strobes.
module mem_interface #(
   parameter int unsigned WAIT_STATES = 1
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic [15:0] SysBus,
   input  logic        AdrLatch,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic        MemWait,
   input  logic [15:0] RData,
   output logic [15:0] DataIn,
   output logic [15:0] Address,
   output logic [15:0] WData,
   output logic        nME,
   output logic        nOE,
   output logic        nWE,
   output logic        Stall,
   output logic        Done
);

   localparam logic [2:0] LP_WAIT = 3'(WAIT_STATES);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETUP,
      S_STROBE,
      S_HOLD
   } state_t;

   state_t      r_state;
   state_t      w_next;
   logic [2:0]  r_count;
   logic [2:0]  w_count_next;
   logic        w_strobe_done;
   logic        r_is_write;
   logic [15:0] r_address;
   logic [15:0] r_wdata;
   logic [15:0] r_datain;
   logic        r_nme;
   logic        r_noe;
   logic        r_nwe;

   // NOTE: every output of this block gets a default first so no path leaves a latch.
   always_comb begin
      w_next        = r_state;
      w_count_next  = r_count;
      w_strobe_done = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (MemWrite || MemRead) begin
               w_next = S_SETUP;
            end
         end
         S_SETUP: begin
            w_next       = S_STROBE;
            w_count_next = LP_WAIT;
         end
         S_STROBE: begin
            if (r_count != 3'd0) begin
               w_count_next = r_count - 3'd1;
            end else if (!MemWait) begin
               w_next        = S_HOLD;
               w_strobe_done = 1'b1;
            end
         end
         S_HOLD: begin
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         r_state    <= S_IDLE;
         r_count    <= 3'd0;
         r_is_write <= 1'b0;
         r_address  <= 16'd0;
         r_wdata    <= 16'd0;
         r_datain   <= 16'd0;
         r_nme      <= 1'b1;
         r_noe      <= 1'b1;
         r_nwe      <= 1'b1;
      end else begin
         r_state <= w_next;
         r_count <= w_count_next;
         // Strobes are decoded from the next state so they leave a flop glitch-free.
         r_nme   <= !((w_next == S_SETUP) || (w_next == S_STROBE));
         r_noe   <= !((w_next == S_STROBE) && !r_is_write);
         r_nwe   <= !((w_next == S_STROBE) && r_is_write);

         if (r_state == S_IDLE) begin
            if (AdrLatch) begin
               r_address <= SysBus;
            end
            if (MemWrite) begin
               r_wdata    <= SysBus;
               r_is_write <= 1'b1;
            end else if (MemRead) begin
               r_is_write <= 1'b0;
            end
         end

         if (w_strobe_done && !r_is_write) begin
            r_datain <= RData;
         end
      end
   end

   assign Stall   = (r_state == S_SETUP) || (r_state == S_STROBE) ||
                    ((r_state == S_IDLE) && (MemRead || MemWrite));
   assign Done    = (r_state == S_HOLD);
   assign DataIn  = r_datain;
   assign Address = r_address;
   assign WData   = r_wdata;
   assign nME     = r_nme;
   assign nOE     = r_noe;
   assign nWE     = r_nwe;

endmodule

// File: tb/tb_mem_interface.sv
// Self-checking bench: two instances (WAIT_STATES 1 and 0) share stimulus; expectations
// come from a per-transaction timing model built from the access rules.
module tb_mem_interface;

   localparam int WS_A = 1;
   localparam int WS_B = 0;

   logic        Clock = 1'b0;
   logic        Reset = 1'b0;
   logic [15:0] SysBus = 16'd0;
   logic        AdrLatch = 1'b0;
   logic        MemRead = 1'b0;
   logic        MemWrite = 1'b0;
   logic        MemWait = 1'b0;
   logic [15:0] RData = 16'd0;

   logic [15:0] din_o   [2];
   logic [15:0] addr_o  [2];
   logic [15:0] wdat_o  [2];
   logic        nme_o   [2];
   logic        noe_o   [2];
   logic        nwe_o   [2];
   logic        stall_o [2];
   logic        done_o  [2];

   int n_vec = 0;
   int n_bad = 0;

   logic [15:0] exp_addr  = 16'd0;
   logic [15:0] exp_wdata = 16'd0;
   logic [15:0] exp_din   [2];

   always #5 Clock = ~Clock;

   mem_interface #(.WAIT_STATES(WS_A)) u_dut_a (
      .Clock(Clock), .Reset(Reset), .SysBus(SysBus), .AdrLatch(AdrLatch),
      .MemRead(MemRead), .MemWrite(MemWrite), .MemWait(MemWait), .RData(RData),
      .DataIn(din_o[0]), .Address(addr_o[0]), .WData(wdat_o[0]),
      .nME(nme_o[0]), .nOE(noe_o[0]), .nWE(nwe_o[0]),
      .Stall(stall_o[0]), .Done(done_o[0])
   );

   mem_interface #(.WAIT_STATES(WS_B)) u_dut_b (
      .Clock(Clock), .Reset(Reset), .SysBus(SysBus), .AdrLatch(AdrLatch),
      .MemRead(MemRead), .MemWrite(MemWrite), .MemWait(MemWait), .RData(RData),
      .DataIn(din_o[1]), .Address(addr_o[1]), .WData(wdat_o[1]),
      .nME(nme_o[1]), .nOE(noe_o[1]), .nWE(nwe_o[1]),
      .Stall(stall_o[1]), .Done(done_o[1])
   );

   function automatic int ws_of(input int i);
      return (i == 0) ? WS_A : WS_B;
   endfunction

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic check_dut(input int i, input string ph, input logic e_me, input logic e_oe,
                            input logic e_we, input logic e_done, input logic e_stall,
                            input logic [15:0] e_din);
      string t;
      t = $sformatf("%s.ws%0d", ph, ws_of(i));
      check({t, ".nME"},     {15'd0, nme_o[i]},   {15'd0, e_me});
      check({t, ".nOE"},     {15'd0, noe_o[i]},   {15'd0, e_oe});
      check({t, ".nWE"},     {15'd0, nwe_o[i]},   {15'd0, e_we});
      check({t, ".Done"},    {15'd0, done_o[i]},  {15'd0, e_done});
      check({t, ".Stall"},   {15'd0, stall_o[i]}, {15'd0, e_stall});
      check({t, ".Address"}, addr_o[i], exp_addr);
      check({t, ".WData"},   wdat_o[i], exp_wdata);
      check({t, ".DataIn"},  din_o[i],  e_din);
   endtask

   task automatic drive(input logic [15:0] bus, input logic al, input logic mr, input logic mw,
                        input logic mwait, input logic [15:0] rd);
      @(posedge Clock);
      #1;
      SysBus   = bus;
      AdrLatch = al;
      MemRead  = mr;
      MemWrite = mw;
      MemWait  = mwait;
      RData    = rd;
   endtask

   task automatic idle_cycles(input string name, input int n);
      for (int c = 0; c < n; c++) begin
         drive(16'($urandom), 1'b0, 1'b0, 1'b0, 1'($urandom), 16'($urandom));
         @(negedge Clock);
         for (int i = 0; i < 2; i++) check_dut(i, {name, ".idle"}, 1, 1, 1, 0, 0, exp_din[i]);
      end
   endtask

   // lmode: 0 keep address, 1 latch in the cycle before the request, 2 latch with the request
   task automatic run_txn(input string name, input bit wr, input bit both, input int lmode,
                          input logic [15:0] addr, input logic [15:0] wd,
                          input bit rrand, input logic [15:0] rconst,
                          input bit mw_rand, input int mw_from, input int mw_to,
                          input bit spurious);
      logic        mwv [16];
      logic [15:0] rdv [16];
      int          e   [2];
      int          last;
      int          first_idle;
      logic [15:0] a;
      logic        busy;
      logic        strb;
      string       ph;
      for (int c = 0; c < 16; c++) begin
         if (mw_rand) mwv[c] = (c >= 2) && (c <= 8) && ($urandom_range(0, 2) == 0);
         else         mwv[c] = (c >= mw_from) && (c <= mw_to);
         rdv[c] = rrand ? 16'($urandom) : rconst;
      end
      // Strobe ends on the first cycle at or after 2+N where MemWait is low.
      for (int i = 0; i < 2; i++) begin
         e[i] = 2 + ws_of(i);
         while (mwv[e[i]]) e[i]++;
      end
      last       = ((e[0] > e[1]) ? e[0] : e[1]) + 1;
      first_idle = ((e[0] < e[1]) ? e[0] : e[1]) + 1;
      a = (lmode == 2 && wr) ? wd : addr;

      if (lmode == 1) begin
         drive(addr, 1'b1, 1'b0, 1'b0, 1'b0, 16'($urandom));
         @(negedge Clock);
         for (int i = 0; i < 2; i++) check_dut(i, {name, ".pre"}, 1, 1, 1, 0, 0, exp_din[i]);
         exp_addr = addr;
      end

      for (int k = 0; k <= last; k++) begin
         if (k == 0)
            drive(wr ? wd : a, lmode == 2, !wr || both, wr, mwv[0], rdv[0]);
         else if (spurious && k <= first_idle)
            drive(16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), mwv[k], rdv[k]);
         else
            drive(16'($urandom), 1'b0, 1'b0, 1'b0, mwv[k], rdv[k]);
         @(negedge Clock);
         ph = $sformatf("%s.c%0d", name, k);
         for (int i = 0; i < 2; i++) begin
            busy = (k >= 1) && (k <= e[i]);
            strb = (k >= 2) && (k <= e[i]);
            check_dut(i, ph, !busy, !(strb && !wr), !(strb && wr), k == e[i] + 1, k <= e[i],
                      (!wr && k >= e[i] + 1) ? rdv[e[i]] : exp_din[i]);
         end
         if (k == 0) begin
            if (lmode == 2) exp_addr = a;
            if (wr) exp_wdata = wd;
         end
      end
      if (!wr) for (int i = 0; i < 2; i++) exp_din[i] = rdv[e[i]];
   endtask

   initial begin
      exp_din[0] = 16'd0;
      exp_din[1] = 16'd0;

      // Asynchronous reset, asserted between clock edges.
      #3 Reset = 1'b1;
      #1;
      for (int i = 0; i < 2; i++) check_dut(i, "reset", 1, 1, 1, 0, 0, 16'd0);
      @(posedge Clock);
      @(posedge Clock);
      #2 Reset = 1'b0;

      run_txn("rd_n1", 1'b0, 1'b0, 1, 16'h0040, 16'h0000, 1'b0, 16'hBEEF, 1'b0, 0, -1, 1'b0);
      run_txn("wr_n0", 1'b1, 1'b0, 1, 16'h1234, 16'hA5A5, 1'b1, 16'h0000, 1'b0, 0, -1, 1'b0);
      run_txn("mwait", 1'b0, 1'b0, 2, 16'h0100, 16'h0000, 1'b1, 16'h0000, 1'b0, 2, 4, 1'b0);
      run_txn("both",  1'b1, 1'b1, 2, 16'h0000, 16'h3C3C, 1'b1, 16'h0000, 1'b0, 0, -1, 1'b1);
      run_txn("ignore", 1'b0, 1'b0, 0, 16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b0, 2, 3, 1'b1);
      idle_cycles("gap", 2);

      // Reset in the middle of a write strobe.
      drive(16'h2222, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
      drive(16'h5A5A, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0);
      drive(16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0);
      drive(16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'd0);
      @(negedge Clock);
      for (int i = 0; i < 2; i++)
         check($sformatf("rst_mid.pre.ws%0d.nWE", ws_of(i)), {15'd0, nwe_o[i]}, 16'd0);
      #2 Reset = 1'b1;
      #1;
      exp_addr   = 16'd0;
      exp_wdata  = 16'd0;
      exp_din[0] = 16'd0;
      exp_din[1] = 16'd0;
      for (int i = 0; i < 2; i++) check_dut(i, "rst_mid", 1, 1, 1, 0, 0, 16'd0);
      @(posedge Clock);
      #2 Reset = 1'b0;
      @(negedge Clock);
      for (int i = 0; i < 2; i++) check_dut(i, "rst_mid.after", 1, 1, 1, 0, 0, 16'd0);
      run_txn("rd_after_rst", 1'b0, 1'b0, 1, 16'h0777, 16'h0000, 1'b1, 16'h0000, 1'b0, 0, -1, 1'b0);

      for (int t = 0; t < 40; t++) begin
         run_txn($sformatf("rnd%0d", t), 1'($urandom), 1'($urandom), int'($urandom_range(0, 2)),
                 16'($urandom), 16'($urandom), 1'b1, 16'h0000, 1'b1, 0, -1, 1'($urandom));
         idle_cycles($sformatf("rnd%0d", t), int'($urandom_range(0, 2)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
